code_packer: RTL

CODE_PACKER -- requirements
Module: code_packer

---
 rtl/code_packer_pkg.sv | 40 ++++
 rtl/code_packer_fifo.sv | 63 ++++++
 rtl/code_packer.sv | 91 +++++++++
 3 files changed

// File: rtl/code_packer_pkg.sv
// Shared constants and the code-byte rule for the code packer.
// The code rule lives here so the top only deals with buffering and framing.
package code_packer_pkg;

  localparam int CODE_W = 10;
  localparam logic [4:0] CODE_TAIL = 5'b11001;
  localparam logic [2:0] CODE_PREFIX = 3'b110;

  typedef enum logic [2:0] {
    SEL_PFX_A = 3'b000,
    SEL_ONES  = 3'b010,
    SEL_ZEROS = 3'b011,
    SEL_PAT   = 3'b101,
    SEL_PFX_B = 3'b110
  } sel_e;

  // Any select value not listed in sel_e falls through to the 8-bit sum.
  function automatic logic [CODE_W-1:0] make_code(
    input logic [2:0] sel,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] pat,
    input logic       sat
  );
    logic [8:0] sum;
    logic [7:0] hi;
    logic [1:0] lo;
    sum = {1'b0, a} + {1'b0, b};
    case (sel)
      SEL_PFX_A, SEL_PFX_B: hi = {CODE_PREFIX, a[4:0]};
      SEL_PAT:              hi = pat;
      SEL_ONES:             hi = 8'hFF;
      SEL_ZEROS:            hi = 8'h00;
      default:              hi = (sat && sum[8]) ? 8'hFF : sum[7:0];
    endcase
    lo = a[6:5] ^ {a[4], b[6]};
    return {hi, lo};
  endfunction

endpackage

// File: rtl/code_packer_fifo.sv
// Synchronous FIFO with occupancy-based full/empty flags.
// Storage is not reset; consumers must qualify rdata with !empty.
module code_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));

endmodule

// File: rtl/code_packer.sv
// Builds a 10-bit code word and a packed operand word per accepted input,
// buffers both in one FIFO entry and counts words delivered downstream.
module code_packer
  import code_packer_pkg::*;
#(
  parameter int         BUS_WIDTH  = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter int         SAT_ADD    = 0,
  parameter logic [7:0] PAT_CODE   = 8'b11100010
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               sel,
  input  logic [BUS_WIDTH-1:0]     a,
  input  logic [BUS_WIDTH-1:0]     b,
  input  logic [BUS_WIDTH-1:0]     enf,
  input  logic [BUS_WIDTH-1:0]     load,
  input  logic [BUS_WIDTH-1:0]     base,
  input  logic [3:0]               qtd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CODE_W-1:0]        code,
  output logic [3*BUS_WIDTH+11:0]  packed_word,
  output logic [15:0]              frame_cnt
);

  localparam int PW = 3 * BUS_WIDTH + 12;
  localparam int LW = BUS_WIDTH + 3;
  localparam int EW = CODE_W + PW;

  logic [LW-1:0]     load_ext;
  logic [LW-1:0]     load_x6;
  logic [CODE_W-1:0] code_in;
  logic [PW-1:0]     packed_in;
  logic [EW-1:0]     head;
  logic              ready_en;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a word stays put until taken.
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_ready  = ready_en && !full;
  assign out_valid = !empty;

  assign load_ext  = LW'(load);
  assign load_x6   = (load_ext << 2) + (load_ext << 1);
  assign packed_in = {enf, load_x6, qtd, base, CODE_TAIL};
  assign code_in   = make_code(sel, a[7:0], b[7:0], PAT_CODE, SAT_ADD != 0);

  // Input side stays closed during reset and opens on the first edge after.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  code_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sysclk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({code_in, packed_in}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Outputs read as zero when nothing is queued, which also covers reset.
  assign code        = out_valid ? head[EW-1 -: CODE_W] : '0;
  assign packed_word = out_valid ? head[PW-1:0] : '0;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (pop) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
